fetch_unit: RTL

Instruction-fetch stage sitting directly upstream of decode/execute and the branch/jump resolution logic. Holds the program counter, issues in-order word requests to instruction memory, buffers up to two returned instructions, and presents them with their PC to decode over a valid/ready handshake. It consumes the taken-branch and jump redirects produced in execute, flushes wrong-path work (buffered and in-flight), and restarts fetch at the resolved target.

---
 rtl/fetch_unit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, in-order imem requests, two-entry instruction buffer, redirect flush.
// Optional FETCH_MISALIGN_CHECK_EN reports misaligned redirect targets instead of aligning them.
module fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_2000,
    parameter int          MAX_INFLIGHT = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic [31:0] fetch_inst,
    output logic [31:0] fetch_pc,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        fetch_misaligned
);

    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam int PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam logic [CW:0]   MAX_C = (CW + 1)'(MAX_INFLIGHT);
    localparam logic [PW-1:0] LAST  = PW'(MAX_INFLIGHT - 1);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        mis;
    } entry_t;

    logic [31:0]   pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] buf_count;
    logic          halted;

    entry_t        buf_mem [MAX_INFLIGHT];
    logic [PW-1:0] buf_rd;
    logic [PW-1:0] buf_wr;

    logic [31:0]   pq_mem [MAX_INFLIGHT];
    logic [PW-1:0] pq_rd;
    logic [PW-1:0] pq_wr;

    logic          redirect;
    logic [31:0]   target_raw;
    logic [31:0]   target;
    logic          tgt_mis;
    logic [CW:0]   occupancy;
    logic          credit;
    logic          req_fire;
    logic          resp_keep;
    logic          resp_drop;
    logic          pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    assign redirect   = jump | branch_taken;
    assign target_raw = jump ? jump_target : branch_target;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign tgt_mis = |target_raw[1:0];
    assign target  = target_raw;
`else
    assign tgt_mis = 1'b0;
    assign target  = target_raw & ~32'd3;
`endif

    // Stale requests still hold a credit until their response is dropped.
    assign occupancy = {1'b0, inflight} + {1'b0, buf_count};
    assign credit    = occupancy < MAX_C;

    assign imem_req_valid = !reset && !redirect && !halted
                          && (drop_cnt == '0) && credit;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign resp_keep = imem_resp_valid && (drop_cnt == '0);
    assign resp_drop = imem_resp_valid && (drop_cnt != '0);

    assign fetch_valid = !reset && (buf_count != '0);
    assign pop         = fetch_valid && fetch_ready;

    assign fetch_inst       = fetch_valid ? buf_mem[buf_rd].inst : 32'd0;
    assign fetch_pc         = fetch_valid ? buf_mem[buf_rd].pc : 32'd0;
    assign fetch_misaligned = fetch_valid && buf_mem[buf_rd].mis;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= RESET_PC;
            inflight  <= '0;
            drop_cnt  <= '0;
            buf_count <= '0;
            halted    <= 1'b0;
            buf_rd    <= '0;
            buf_wr    <= '0;
            pq_rd     <= '0;
            pq_wr     <= '0;
        end else if (redirect) begin
            // Everything outstanding after this edge belongs to the wrong path.
            pc        <= target;
            inflight  <= inflight - CW'(imem_resp_valid);
            drop_cnt  <= inflight - CW'(imem_resp_valid);
            buf_count <= CW'(tgt_mis);
            halted    <= tgt_mis;
            buf_rd    <= '0;
            buf_wr    <= tgt_mis ? nxt('0) : '0;
            pq_rd     <= '0;
            pq_wr     <= '0;
            if (tgt_mis) begin
                buf_mem[{PW{1'b0}}] <= '{inst: 32'd0, pc: target, mis: 1'b1};
            end
        end else begin
            if (req_fire) begin
                pq_mem[pq_wr] <= pc;
                pq_wr         <= nxt(pq_wr);
                pc            <= pc + 32'd4;
            end
            if (resp_keep) begin
                buf_mem[buf_wr] <= '{inst: imem_resp_data,
                                     pc:   pq_mem[pq_rd],
                                     mis:  1'b0};
                buf_wr <= nxt(buf_wr);
                pq_rd  <= nxt(pq_rd);
            end
            if (resp_drop) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
            if (pop) begin
                buf_rd <= nxt(buf_rd);
            end
            inflight  <= inflight + CW'(req_fire) - CW'(imem_resp_valid);
            buf_count <= buf_count + CW'(resp_keep) - CW'(pop);
        end
    end

endmodule
